// File: rtl/tick_scheduler.sv
// tick_scheduler: run/pause/step controller producing a one-cycle tick enable
// and a 50% clk_div square wave from four selectable period presets.
// Ports: clk, rst (sync, active-high); cmd_run/stop/pause/step commands;
// rate_sel (preset select); burst_len (ticks per run, 0 = continuous);
// tick, clk_div, state (IDLE=0 RUN=1 HOLD=2 STEP=3), busy, done.
// Optional feature macro: TICK_SCHED_BURST_EN enables burst counting/done.
module tick_scheduler #(
  parameter logic [31:0] DIV0 = 32'd10000000,
  parameter logic [31:0] DIV1 = 32'd5000000,
  parameter logic [31:0] DIV2 = 32'd2500000,
  parameter logic [31:0] DIV3 = 32'd1000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_run,
  input  logic       cmd_stop,
  input  logic       cmd_pause,
  input  logic       cmd_step,
  input  logic [1:0] rate_sel,
  input  logic [7:0] burst_len,
  output logic       tick,
  output logic       clk_div,
  output logic [1:0] state,
  output logic       busy,
  output logic       done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2,
    STEP = 2'd3
  } state_t;

  function automatic logic [31:0] clamp(input logic [31:0] v);
    return (v < 32'd2) ? 32'd2 : v;
  endfunction

  state_t      st, st_n;
  logic [31:0] cnt, cnt_n;
  logic [31:0] div_act, div_n;
  logic [31:0] preset;
  logic        ret, ret_n;
  logic        clk_div_n;
  logic        tick_int;
  logic        burst_end;

  always_comb begin
    case (rate_sel)
      2'd0: preset = clamp(DIV0);
      2'd1: preset = clamp(DIV1);
      2'd2: preset = clamp(DIV2);
      default: preset = clamp(DIV3);
    endcase
  end

  assign tick_int = ((st == RUN) && (cnt == div_act - 32'd1))
                  || (st == STEP);

`ifdef TICK_SCHED_BURST_EN
  logic [7:0] rem;
  logic       done_q;

  // Last tick of a burst only matters while running.
  assign burst_end = (st == RUN) && tick_int && (rem == 8'd1);

  always_ff @(posedge clk) begin
    if (rst) begin
      rem    <= 8'd0;
      done_q <= 1'b0;
    end else begin
      done_q <= burst_end && !cmd_stop;
      if (!cmd_stop) begin
        if (st == IDLE && cmd_run)
          rem <= burst_len;
        else if (st == RUN && tick_int && rem != 8'd0)
          rem <= rem - 8'd1;
      end
    end
  end

  assign done = done_q;
`else
  logic unused_burst;
  assign unused_burst = ^burst_len;
  assign burst_end    = 1'b0;
  assign done         = 1'b0;
`endif

  always_comb begin
    st_n      = st;
    cnt_n     = cnt;
    div_n     = div_act;
    ret_n     = ret;
    clk_div_n = clk_div;
    if (cmd_stop) begin
      // A tick decoded this cycle still shows, but its toggle is dropped.
      st_n      = IDLE;
      cnt_n     = 32'd0;
      clk_div_n = 1'b0;
    end else begin
      unique case (st)
        IDLE: begin
          if (cmd_run) begin
            st_n  = RUN;
            cnt_n = 32'd0;
            div_n = preset;
          end else if (cmd_step) begin
            st_n  = STEP;
            ret_n = 1'b0;
          end
        end
        RUN: begin
          if (tick_int) begin
            // New rate only takes effect at a period boundary.
            cnt_n     = 32'd0;
            div_n     = preset;
            clk_div_n = ~clk_div;
          end else begin
            cnt_n = cnt + 32'd1;
          end
          if (burst_end)
            st_n = IDLE;
          else if (cmd_pause)
            st_n = HOLD;
        end
        HOLD: begin
          if (cmd_pause) begin
            st_n = RUN;
          end else if (cmd_step) begin
            st_n  = STEP;
            ret_n = 1'b1;
          end
        end
        STEP: begin
          clk_div_n = ~clk_div;
          st_n      = ret ? HOLD : IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst)
      st <= IDLE;
    else
      st <= st_n;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt     <= 32'd0;
      div_act <= clamp(DIV0);
      ret     <= 1'b0;
      clk_div <= 1'b0;
    end else begin
      cnt     <= cnt_n;
      div_act <= div_n;
      ret     <= ret_n;
      clk_div <= clk_div_n;
    end
  end

  assign tick  = tick_int;
  assign state = st;
  assign busy  = (st != IDLE);

endmodule

// File: tb/tb_tick_scheduler.sv
// tb_tick_scheduler: table vectors, hand sequences and a randomized run
// against a behavioural model for tick_scheduler.
module tb_tick_scheduler;

  localparam logic [31:0] D0 = 32'd4;
  localparam logic [31:0] D1 = 32'd6;
  localparam logic [31:0] D2 = 32'd2;
  localparam logic [31:0] D3 = 32'd10;
`ifdef TICK_SCHED_BURST_EN
  localparam bit BURST = 1'b1;
`else
  localparam bit BURST = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cmd_run = 1'b0;
  logic       cmd_stop = 1'b0;
  logic       cmd_pause = 1'b0;
  logic       cmd_step = 1'b0;
  logic [1:0] rate_sel = 2'd0;
  logic [7:0] burst_len = 8'd0;
  logic       tick, clk_div, busy, done;
  logic [1:0] state;

  int n_checks = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  tick_scheduler #(.DIV0(D0), .DIV1(D1), .DIV2(D2), .DIV3(D3)) dut (
    .clk(clk), .rst(rst),
    .cmd_run(cmd_run), .cmd_stop(cmd_stop),
    .cmd_pause(cmd_pause), .cmd_step(cmd_step),
    .rate_sel(rate_sel), .burst_len(burst_len),
    .tick(tick), .clk_div(clk_div), .state(state),
    .busy(busy), .done(done)
  );

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  task automatic chk_all(input string nm, input logic et, input logic ed,
                         input logic [1:0] es, input logic edn);
    chk({nm, ".tick"}, tick, et);
    chk({nm, ".clk_div"}, clk_div, ed);
    chk({nm, ".state"}, state, es);
    chk({nm, ".busy"}, busy, es != 2'd0);
    chk({nm, ".done"}, done, edn);
  endtask

  task automatic clr_cmds();
    cmd_run = 0; cmd_stop = 0; cmd_pause = 0; cmd_step = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    clr_cmds();
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  typedef struct {
    logic       run, stop;
    logic [1:0] rate;
    logic       e_tick, e_div;
    logic [1:0] e_state;
  } vec_t;

  vec_t tbl[16];

  function automatic vec_t mk(input logic r, input logic s,
                              input logic [1:0] rt, input logic et,
                              input logic ed, input logic [1:0] es);
    vec_t v;
    v.run = r; v.stop = s; v.rate = rt;
    v.e_tick = et; v.e_div = ed; v.e_state = es;
    return v;
  endfunction

  // Behavioural model: a mode plus elapsed cycles in the current period.
  int unsigned pre[4];
  int          m_mode;
  int unsigned m_elapsed, m_period, m_left;
  bit          m_back_to_hold, m_sq, m_done;

  function automatic bit m_tick();
    return (m_mode == 1 && m_elapsed + 1 == m_period) || m_mode == 3;
  endfunction

  task automatic m_reset();
    m_mode = 0; m_elapsed = 0; m_period = pre[0]; m_left = 0;
    m_back_to_hold = 0; m_sq = 0; m_done = 0;
  endtask

  task automatic m_step(input bit r, input bit s, input bit p, input bit st,
                        input int rt, input int bl);
    bit t;
    t = m_tick();
    m_done = 0;
    if (s) begin
      m_mode = 0; m_elapsed = 0; m_sq = 0;
    end else if (m_mode == 0) begin
      if (r) begin
        m_mode = 1; m_elapsed = 0; m_period = pre[rt];
        m_left = BURST ? bl : 0;
      end else if (st) begin
        m_mode = 3; m_back_to_hold = 0;
      end
    end else if (m_mode == 1) begin
      if (t) begin
        m_elapsed = 0; m_period = pre[rt]; m_sq = !m_sq;
        if (m_left == 1) begin
          m_left = 0; m_mode = 0; m_done = 1;
        end else if (m_left > 1) begin
          m_left--;
        end
      end else begin
        m_elapsed++;
      end
      if (m_mode == 1 && p) m_mode = 2;
    end else if (m_mode == 2) begin
      if (p) m_mode = 1;
      else if (st) begin
        m_mode = 3; m_back_to_hold = 1;
      end
    end else begin
      m_sq = !m_sq;
      m_mode = m_back_to_hold ? 2 : 0;
    end
  endtask

  initial begin
    pre[0] = D0; pre[1] = D1; pre[2] = D2; pre[3] = D3;

    // Run at rate 0, switch to rate 1 mid-period, then stop+run on a tick.
    tbl[0]  = mk(1, 0, 0, 0, 0, 0);
    tbl[1]  = mk(0, 0, 0, 0, 0, 1);
    tbl[2]  = mk(0, 0, 0, 0, 0, 1);
    tbl[3]  = mk(0, 0, 0, 0, 0, 1);
    tbl[4]  = mk(0, 0, 0, 1, 0, 1);
    tbl[5]  = mk(0, 0, 0, 0, 1, 1);
    tbl[6]  = mk(0, 0, 1, 0, 1, 1);
    tbl[7]  = mk(0, 0, 1, 0, 1, 1);
    tbl[8]  = mk(0, 0, 1, 1, 1, 1);
    tbl[9]  = mk(0, 0, 1, 0, 0, 1);
    tbl[10] = mk(0, 0, 1, 0, 0, 1);
    tbl[11] = mk(0, 0, 1, 0, 0, 1);
    tbl[12] = mk(0, 0, 1, 0, 0, 1);
    tbl[13] = mk(0, 0, 1, 0, 0, 1);
    tbl[14] = mk(1, 1, 1, 1, 0, 1);
    tbl[15] = mk(0, 0, 1, 0, 0, 0);

    do_reset();
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      chk_all($sformatf("vec%0d", i), tbl[i].e_tick, tbl[i].e_div,
              tbl[i].e_state, 1'b0);
      cmd_run  = tbl[i].run;
      cmd_stop = tbl[i].stop;
      rate_sel = tbl[i].rate;
    end
    clr_cmds();

    // Pause at cnt=1, hold, single step, resume.
    do_reset();
    @(negedge clk);
    rate_sel = 0; burst_len = 0; cmd_run = 1;
    @(negedge clk); cmd_run = 0;
    @(negedge clk); cmd_pause = 1;
    @(negedge clk); cmd_pause = 0;
    chk("pause.enter", state, 2'd2);
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      chk("hold.tick", tick, 1'b0);
      chk("hold.state", state, 2'd2);
    end
    cmd_step = 1;
    @(negedge clk); cmd_step = 0;
    chk_all("step", 1'b1, 1'b0, 2'd3, 1'b0);
    @(negedge clk);
    chk_all("step.back", 1'b0, 1'b1, 2'd2, 1'b0);
    cmd_pause = 1;
    @(negedge clk); cmd_pause = 0;
    chk_all("resume", 1'b0, 1'b1, 2'd1, 1'b0);
    @(negedge clk);
    chk_all("resume.tick", 1'b1, 1'b1, 2'd1, 1'b0);
    @(negedge clk);
    chk("resume.div", clk_div, 1'b0);

    // Burst of 3 at the fastest rate.
    do_reset();
    @(negedge clk);
    rate_sel = 2; burst_len = 3; cmd_run = 1;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk); cmd_run = 0;
      if (BURST) begin
        chk($sformatf("burst.t%0d", c), tick, (c == 2 || c == 4 || c == 6));
        chk($sformatf("burst.d%0d", c), done, c == 7);
        if (c >= 7) chk("burst.idle", state, 2'd0);
      end else begin
        chk($sformatf("cont.t%0d", c), tick, (c % 2) == 0);
        chk($sformatf("cont.d%0d", c), done, 1'b0);
        chk("cont.run", state, 2'd1);
      end
    end
    burst_len = 0;

    // Reset in the middle of a run while clk_div is high.
    do_reset();
    @(negedge clk);
    rate_sel = 0; cmd_run = 1;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk); cmd_run = 0;
    end
    chk("prerst.div", clk_div, 1'b1);
    rst = 1;
    @(negedge clk); rst = 0;
    chk_all("rst", 1'b0, 1'b0, 2'd0, 1'b0);
    cmd_run = 1;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk); cmd_run = 0;
      chk($sformatf("rerun.t%0d", c), tick, c == 4);
    end

    // Randomized commands against the model.
    do_reset();
    m_reset();
    for (int c = 0; c < 4000; c++) begin
      bit r, s, p, st;
      int rt, bl;
      @(negedge clk);
      chk_all("rand", m_tick(), m_sq, m_mode[1:0], m_done);
      if (n_fail > 20) break;
      s  = $urandom_range(0, 99) < 2;
      r  = $urandom_range(0, 99) < 10;
      p  = $urandom_range(0, 99) < 6;
      st = $urandom_range(0, 99) < 8;
      rt = $urandom_range(0, 3);
      bl = $urandom_range(0, 4);
      cmd_stop = s; cmd_run = r; cmd_pause = p; cmd_step = st;
      rate_sel = rt[1:0]; burst_len = bl[7:0];
      m_step(r, s, p, st, rt, bl);
    end
    clr_cmds();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/tick_scheduler.md
# tick_scheduler

Run/pause/step controller for the design's slow-time base. Replaces free-running derived clocks with a one-cycle `tick` enable, plus a legacy 50 % square-wave `clk_div`, for the up/down counter and display logic. Provides four selectable division presets, glitch-free rate changes at tick boundaries, single-step ticks and optional fixed-length bursts.

## Interface
- `DIV0`, default 10000000: preset period in `clk` cycles for `rate_sel`=0.
- `DIV1`, default 5000000: preset period for `rate_sel`=1.
- `DIV2`, default 2500000: preset period for `rate_sel`=2.
- `DIV3`, default 1000000: preset period for `rate_sel`=3.
- All presets are 32-bit. Values below 2 are clamped to 2.
- `clk` input 1: system clock; all logic on rising edge.
- `rst` input 1: synchronous, active-high reset.
- `cmd_run` input 1: level-sampled; start from IDLE.
- `cmd_stop` input 1: abort to IDLE from any state.
- `cmd_pause` input 1: RUN→HOLD, HOLD→RUN.
- `cmd_step` input 1: one tick from IDLE or HOLD.
- `rate_sel` input 2: preset select.
- `burst_len` input 8: ticks per run; 0 means continuous.
- `tick` output 1: one-cycle enable.
- `clk_div` output 1: toggles after every tick.
- `state` output 2: IDLE=0, RUN=1, HOLD=2, STEP=3.
- `busy` output 1: `state`≠IDLE.
- `done` output 1: one-cycle pulse when a burst completes.

## Operation
- Internal registers:
  - `cnt[31:0]`: cycle counter.
  - `div_act[31:0]`: active period.
  - `rem[7:0]`: remaining burst ticks.
  - `ret`: STEP return target (0=IDLE, 1=HOLD).
- `tick` = (state==RUN && cnt==div_act-1) || state==STEP. It is Moore, decoded from registers.
- Command priority is `cmd_stop` > `cmd_run` > `cmd_pause` > `cmd_step`. A command not valid in the current state is ignored.
- IDLE:
  - `cmd_run` → RUN: `cnt`←0, `div_act`←preset(`rate_sel`), `rem`←`burst_len`.
  - Otherwise `cmd_step` → STEP with `ret`←0.
- RUN:
  - `cnt` increments, wrapping to 0 on a tick cycle.
  - On each tick cycle, `div_act`←preset(`rate_sel`). Rate changes never shorten or split a period.
  - `cmd_pause` → HOLD.
  - `cmd_run` is ignored.
- HOLD:
  - `cnt`, `rem` and `div_act` are frozen.
  - `cmd_pause` → RUN; counting resumes from the frozen `cnt`.
  - Otherwise `cmd_step` → STEP with `ret`←1.
- STEP:
  - Lasts exactly one cycle with `tick`=1, then returns to IDLE or HOLD per `ret`.
  - Does not modify `cnt` or `rem`.
  - Commands are ignored except `cmd_stop`.
- `cmd_stop`, any state → IDLE next cycle:
  - `cnt`←0, `clk_div`←0, no `done`.
  - A tick already decoded in that cycle still appears on `tick`, but its `clk_div` toggle is suppressed.
- Burst (nonzero latched `rem`):
  - Each RUN tick decrements `rem`.
  - A tick with `rem`==1 moves to IDLE; `done`=1 during the first IDLE cycle.
- Pause in a tick cycle: the tick is issued and counted, `cnt` wraps to 0, then HOLD.
- `clk_div` toggles at the edge ending every tick cycle, both RUN and STEP.

## Timing
- Reset values: state=IDLE, `tick`=0, `clk_div`=0, `busy`=0, `done`=0, `cnt`=0, `rem`=0, `div_act`=preset 0.
- `cmd_run` sampled at edge t:
  - RUN from cycle t+1 with `cnt`=0.
  - First `tick` in cycle t+D, where D=`div_act`.
  - Further ticks every D cycles.
- `cmd_step` sampled at edge t: `tick` high in cycle t+1 only; back in IDLE/HOLD at t+2.
- `clk_div` changes one cycle after the corresponding `tick`. Half-period is D cycles.
- `done` rises one cycle after the final burst tick.
- `busy` and `state` are registered with zero combinational delay from commands. Commands take effect the cycle after sampling.

## Configuration
- `TICK_SCHED_BURST_EN` defined:
  - Burst logic (`rem`, `done`) is present as described.
- Not defined:
  - `burst_len` is ignored and every run is continuous.
  - `rem` logic is removed.
  - `done` is tied to 0.
  - All other behaviour is identical.

## Test plan
Bench parameters for all scenarios: DIV0=4, DIV1=6, DIV2=2, DIV3=10.
- Reset, then `cmd_run` with `rate_sel`=0, `burst_len`=0 → `tick` at RUN cycles 4, 8, 12; `clk_div` pattern 0000 1111 0000; `busy`=1.
- Switch `rate_sel` 0→1 mid-period → current period completes at 4, next period is 6 cycles, no short tick.
- With `TICK_SCHED_BURST_EN`, `burst_len`=3, DIV2 → ticks at cycles 2, 4, 6; IDLE plus `done`=1 at cycle 7. Without the macro → ticks continue and `done` stays 0.
- `cmd_pause` at `cnt`=1 → HOLD, no ticks for 20 cycles. `cmd_step` → one tick, back to HOLD. `cmd_pause` → next tick 2 cycles after resume.
- Simultaneous `cmd_stop`+`cmd_run` in RUN on a tick cycle → tick seen that cycle, then IDLE, `clk_div`=0, `done`=0.
- Assert `rst` mid-RUN with `clk_div`=1 → next cycle all outputs at reset values; `cmd_run` restarts cleanly from `cnt`=0.
